div_iter: RTL and testbench

Iterative radix-2 restoring divider for the EX stage of the 5-stage MIPS pipeline. It consumes the EX-stage divide decode (`DIV`/`DIVU` from `ALUControlE`) and the forwarded operands. It produces quotient and remainder for the HI/LO write path. While an operation is in flight it holds the ID/EX and earlier stages through `stall`.

---
 rtl/div_iter_pkg.sv | 25 ++
 rtl/div_iter.sv | 155 +++++++++++++++
 tb/tb_div_iter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// Shared pipeline definitions used by the iterative divider: divide ALU codes,
// divider FSM state encoding and the default datapath width.
package div_iter_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] ALU_DIV  = 4'b1010;
  localparam logic [3:0] ALU_DIVU = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // EX-stage decode helpers so the datapath can derive start/signed_op from ALUControlE
  function automatic logic is_div_op(input logic [3:0] alu_ctrl);
    return (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_DIVU);
  endfunction

  function automatic logic is_signed_div(input logic [3:0] alu_ctrl);
    return (alu_ctrl == ALU_DIV);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage; produces LO (quotient)
// and HI (remainder) and stalls the front of the pipeline while in flight.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en && v[WIDTH-1]) begin
      r = negate(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

  div_state_t       state;
  div_state_t       next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             accept;
  logic             last_iter;

  assign accept    = start & ~flush;
  assign last_iter = (count == LAST_COUNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (divisor == '0) ? DONE : BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          next_state = IDLE;
        end else if (last_iter) begin
          next_state = DONE;
        end else begin
          next_state = BUSY;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pipeline stall: EX is released in the DONE cycle even with start still high
  always_comb begin
    stall = accept & (state != DONE);
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor
  always_comb begin
    trial    = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_step = {quo[WIDTH-2:0], ~trial[WIDTH]};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
    end else begin
      rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
    end
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op & dividend[WIDTH-1];
            quo   <= abs_val(dividend, signed_op);
            dvs   <= abs_val(divisor, signed_op);
            rem   <= '0;
            count <= '0;
            // Divide by zero skips BUSY; the raw dividend is the remainder
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        BUSY: begin
          if (!flush) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + {{(CW-1){1'b0}}, 1'b1};
            if (last_iter) begin
              quotient  <= neg_q ? negate(quo_step) : quo_step;
              remainder <= neg_r ? negate(rem_step) : rem_step;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_q;
  logic [31:0] last_r;

  div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .flush     (flush),
    .dividend  (dividend),
    .divisor   (divisor),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the architectural special cases
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Called one step after a rising edge with the divider idle; returns one
  // step after the edge that leaves DONE, with start still asserted.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er);
    int cyc;
    int stalls;
    int exp_cyc;
    exp_cyc   = (b == 32'd0) ? 1 : 33;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    flush     = 1'b0;
    start     = 1'b1;
    cyc       = 0;
    stalls    = 0;
    #1;
    while (done !== 1'b1 && cyc < 100) begin
      if (stall === 1'b1) stalls++;
      if (cyc == 1 && b != 32'd0) check({tag, " busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " done_cycle"}, cyc, exp_cyc);
    check({tag, " stall_cycles"}, stalls, exp_cyc);
    check({tag, " stall_in_done"}, {31'd0, stall}, 32'd0);
    check({tag, " q"}, quotient, eq);
    check({tag, " r"}, remainder, er);
    last_q = eq;
    last_r = er;
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        s;
    int          dones;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; flush = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    #12;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst q", quotient, 32'd0);
    check("rst r", remainder, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("u-7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1);
    run_op("sdiv0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("udiv0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op("u9_3_b2b", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // Flush in cycle 10 of 50 / 5
    dividend = 32'd50; divisor = 32'd5; signed_op = 1'b0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    #1;
    check("flush stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush q_hold", quotient, last_q);
    check("flush r_hold", remainder, last_r);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check("flush no_done", dones, 0);
    run_op("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0);

    // Randomized operands against the reference model
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 20));
        1: b = $urandom;
        2: b = 32'd0;
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      model(a, b, s, eq, er);
      run_op("rand", a, b, s, eq, er);
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b0;
        @(posedge clk);
        #1;
      end
    end

    // Asynchronous reset in the middle of a BUSY cycle
    dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst q", quotient, 32'd0);
    check("arst r", remainder, 32'd0);
    check("arst stall", {31'd0, stall}, 32'd1);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    run_op("u255_16", 32'd255, 32'd16, 1'b0, 32'd15, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
